// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI scan controller.
//   scan_state_e : scan FSM state encoding
//   READ_OP      : opcode placed in the top bits of a channel-select read
//   NOP_CMD      : all-zero command, sent on the last frame of a scan
//   ch_width()   : channel index width for a given channel count (min 1)
package adc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_CONV  = 2'd2
    } scan_state_e;

    localparam int          READ_OP_W = 5;
    localparam logic [4:0]  READ_OP   = 5'b11001;
    localparam logic [63:0] NOP_CMD   = '0;

    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/adc_spi_scan_ctrl_spi_frame_engine.sv
// One cs_n-low SPI frame, mode 0.
//   go      : start a frame (ignored while a frame is running)
//   cmd     : command word, shifted out MSB first on mosi
//   miso    : ADC serial data, sampled on the clk cycle sclk rises
//   cs_n    : low for exactly FRAME_W*2*CLK_DIV clk cycles
//   sclk    : registered serial clock, idles low
//   mosi    : serial command, 0 whenever cs_n is high
//   done    : combinational, high on the clk cycle whose edge ends the frame
//   rx_data : first DATA_W miso samples of the latest frame, MSB first
module spi_frame_engine #(
    parameter int DATA_W  = 16,
    parameter int FRAME_W = 32,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [FRAME_W-1:0] cmd,
    input  logic               miso,
    output logic               cs_n,
    output logic               sclk,
    output logic               mosi,
    output logic               done,
    output logic [DATA_W-1:0]  rx_data
);

    localparam int HALF_N = 2 * FRAME_W;
    localparam int HALF_W = $clog2(HALF_N);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic               active_q, active_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               tick;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        div_d    = div_q;
        half_d   = half_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        tick     = active_q && (div_q == '0);
        // The last falling point of sclk is also the edge that raises cs_n.
        done     = tick && sclk_q && (half_q == HALF_W'(HALF_N - 1));

        if (!active_q) begin
            if (go) begin
                active_d = 1'b1;
                sclk_d   = 1'b0;
                div_d    = DIV_W'(CLK_DIV - 1);
                half_d   = '0;
                mosi_d   = cmd[FRAME_W-1];
                tx_d     = cmd << 1;
            end
        end else if (tick) begin
            div_d  = DIV_W'(CLK_DIV - 1);
            half_d = half_q + 1'b1;
            if (!sclk_q) begin
                sclk_d = 1'b1;
                // half_q is even on a rising point; half_q/2 is the bit index.
                if ((int'(half_q) >> 1) < DATA_W) begin
                    rx_d = DATA_W'({rx_q, miso});
                end
            end else begin
                sclk_d = 1'b0;
                if (done) begin
                    active_d = 1'b0;
                    mosi_d   = 1'b0;
                end else begin
                    mosi_d = tx_q[FRAME_W-1];
                    tx_d   = tx_q << 1;
                end
            end
        end else begin
            div_d = div_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            div_q    <= div_d;
            half_q   <= half_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign cs_n    = ~active_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/adc_spi_scan_ctrl.sv
// Multi-channel scan controller for a SAR ADC behind SPI with a ready pin.
// Walks the latched channel mask in ascending order, one frame per channel
// plus a trailing NOP frame; each frame returns the previous frame's result.
//   start/cont_en/ch_mask : scan trigger, continuous enable, channel mask
//   busy                  : scan in progress
//   dout/dout_ch/dout_valid : result, its channel, one-cycle strobe
//   timeout_err           : one-cycle strobe when rvs never came
//   rvs/miso              : ADC ready and serial data
//   cs_n/sclk/mosi        : SPI pins (mode 0)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no scan; waiting for start or cont_en with a non-zero mask
// ST_FRAME | cs_n low, frame engine shifting command out and result in
// ST_CONV  | cs_n high; min T_CSH, then rvs (or re-arm of a continuous scan)
module adc_spi_scan_ctrl
    import adc_spi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAME_W = 32,
    parameter int CLK_DIV = 2,
    parameter int N_CH    = 4,
    parameter int CH_W    = ch_width(N_CH),
    parameter int T_CSH   = 100,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont_en,
    input  logic [N_CH-1:0]   ch_mask,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic [CH_W-1:0]   dout_ch,
    output logic              dout_valid,
    output logic              timeout_err,
    input  logic              rvs,
    input  logic              miso,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi
);

    localparam int CSH_W    = (T_CSH > 0) ? $clog2(T_CSH + 1) : 1;
    localparam int TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CSH_LOAD = (T_CSH > 0) ? T_CSH - 1 : 0;
    localparam int TO_LOAD  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    scan_state_e       state_q, state_d;
    logic [N_CH-1:0]   rem_q, rem_d;
    logic              cur_vld_q, cur_vld_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic              pend_vld_q, pend_vld_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic              rearm_q, rearm_d;
    logic [CSH_W-1:0]  csh_q, csh_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CH_W-1:0]   dout_ch_q, dout_ch_d;
    logic              dout_valid_q, dout_valid_d;
    logic              timeout_err_q, timeout_err_d;

    logic [N_CH-1:0]    walk_src;
    logic [CH_W-1:0]    nxt_ch;
    logic               nxt_found;
    logic [FRAME_W-1:0] cmd;
    logic               launch;
    logic               go;
    logic               frame_done;
    logic [DATA_W-1:0]  rx_data;

    spi_frame_engine #(
        .DATA_W  (DATA_W),
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .cmd     (cmd),
        .miso    (miso),
        .cs_n    (cs_n),
        .sclk    (sclk),
        .mosi    (mosi),
        .done    (frame_done),
        .rx_data (rx_data)
    );

    // Mask walker: the live mask is only looked at when a scan starts from
    // idle; inside a scan the remaining-channel copy is used.
    always_comb begin
        walk_src  = (state_q == ST_IDLE) ? ch_mask : rem_q;
        nxt_found = |walk_src;
        nxt_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (walk_src[i]) nxt_ch = CH_W'(i);
        end
        cmd = FRAME_W'(NOP_CMD);
        if (nxt_found) begin
            cmd = FRAME_W'({READ_OP, nxt_ch}) << (FRAME_W - READ_OP_W - CH_W);
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        cur_vld_d     = cur_vld_q;
        cur_ch_d      = cur_ch_q;
        pend_vld_d    = pend_vld_q;
        pend_ch_d     = pend_ch_q;
        rearm_d       = rearm_q;
        csh_d         = (csh_q != '0) ? csh_q - 1'b1 : csh_q;
        to_d          = (to_q != '0) ? to_q - 1'b1 : to_q;
        dout_d        = dout_q;
        dout_ch_d     = dout_ch_q;
        dout_valid_d  = 1'b0;
        timeout_err_d = 1'b0;
        launch        = 1'b0;
        go            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((start || cont_en) && nxt_found) launch = 1'b1;
            end
            ST_FRAME: begin
                if (frame_done) begin
                    if (pend_vld_q) begin
                        dout_d       = rx_data;
                        dout_ch_d    = pend_ch_q;
                        dout_valid_d = 1'b1;
                    end
                    if (cur_vld_q) begin
                        state_d = ST_CONV;
                        csh_d   = CSH_W'(CSH_LOAD);
                        to_d    = TO_W'(TO_LOAD);
                    end else if (cont_en && (|ch_mask)) begin
                        // Next continuous scan: only the cs_n-high time applies.
                        state_d = ST_CONV;
                        rem_d   = ch_mask;
                        rearm_d = 1'b1;
                        csh_d   = CSH_W'(CSH_LOAD);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CONV: begin
                if ((csh_q == '0) && (rvs || rearm_q)) begin
                    launch = 1'b1;
                end else if (!rearm_q && (to_q == '0)) begin
                    timeout_err_d = 1'b1;
                    cur_vld_d     = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            go         = 1'b1;
            state_d    = ST_FRAME;
            rem_d      = walk_src & ~(N_CH'(1) << nxt_ch);
            pend_vld_d = cur_vld_q;
            pend_ch_d  = cur_ch_q;
            cur_vld_d  = nxt_found;
            cur_ch_d   = nxt_ch;
            rearm_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            cur_vld_q     <= 1'b0;
            cur_ch_q      <= '0;
            pend_vld_q    <= 1'b0;
            pend_ch_q     <= '0;
            rearm_q       <= 1'b0;
            csh_q         <= '0;
            to_q          <= '0;
            dout_q        <= '0;
            dout_ch_q     <= '0;
            dout_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            cur_vld_q     <= cur_vld_d;
            cur_ch_q      <= cur_ch_d;
            pend_vld_q    <= pend_vld_d;
            pend_ch_q     <= pend_ch_d;
            rearm_q       <= rearm_d;
            csh_q         <= csh_d;
            to_q          <= to_d;
            dout_q        <= dout_d;
            dout_ch_q     <= dout_ch_d;
            dout_valid_q  <= dout_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign dout        = dout_q;
    assign dout_ch     = dout_ch_q;
    assign dout_valid  = dout_valid_q;
    assign timeout_err = timeout_err_q;

endmodule
